// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing logic: ALU operand/opcode widths,
// the arbiter FSM state encoding, and a small wrap-around increment helper.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 3;
    localparam int ALU_DW   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Cyclic successor of idx in 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant: picks the first valid bit at or
// after ptr, searching cyclically.
//   valid [NREQ]  request bits
//   ptr   [IDXW]  search start position (must be < NREQ)
//   grant [NREQ]  one-hot grant, all-zero when nothing is valid
//   idx   [IDXW]  index of the granted bit (0 when nothing is valid)
//   any           at least one valid bit
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // pos[k] is the requester examined k-th in the cyclic search.
    logic [IDXW-1:0] pos [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pos
            logic [IDXW:0] pos_sum;
            assign pos_sum = {1'b0, ptr} + (IDXW+1)'(gi);
            assign pos[gi] = (pos_sum >= (IDXW+1)'(NREQ))
                           ? IDXW'(pos_sum - (IDXW+1)'(NREQ))
                           : IDXW'(pos_sum);
        end
    endgenerate

    // Scan from the far end back toward ptr so the nearest valid bit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid[pos[k]]) begin
                grant         = '0;
                grant[pos[k]] = 1'b1;
                idx           = pos[k];
                any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one registered ALU between NREQ requesters. One operation is in
// flight at a time: accept a request, drive the ALU with alu_en high for
// ALU_LAT cycles, capture y/zero, and hold the response until the owning
// requester takes it. alu_op/a/b hold their last issued values while idle so
// the ALU inputs do not toggle.
//   clk, rst_n               clock, async active-low reset
//   req_valid/ready [NREQ]   request handshake (ready one-hot, IDLE only)
//   req_op [3*NREQ], req_a/req_b [8*NREQ]   per-requester payload
//   rsp_valid/ready [NREQ]   response handshake (valid one-hot to owner)
//   rsp_y [8], rsp_zero      captured result
//   busy                     FSM not in IDLE
//   alu_en/op/a/b            ALU drive; alu_y/alu_zero ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_op,
    input  logic [8*NREQ-1:0]      req_a,
    input  logic [8*NREQ-1:0]      req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [ALU_DW-1:0]      rsp_y,
    output logic                   rsp_zero,
    output logic                   busy,
    output logic                   alu_en,
    output logic [ALU_OP_W-1:0]    alu_op,
    output logic [ALU_DW-1:0]      alu_a,
    output logic [ALU_DW-1:0]      alu_b,
    input  logic [ALU_DW-1:0]      alu_y,
    input  logic                   alu_zero
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CW   = $clog2(ALU_LAT + 1);

    state_t                state_reg, state_next;
    logic [IDXW-1:0]       ptr_reg,   ptr_next;
    logic [IDXW-1:0]       gidx_reg,  gidx_next;
    logic [CW-1:0]         cnt_reg,   cnt_next;
    logic [ALU_OP_W-1:0]   op_reg,    op_next;
    logic [ALU_DW-1:0]     a_reg,     a_next;
    logic [ALU_DW-1:0]     b_reg,     b_next;
    logic [ALU_DW-1:0]     y_reg,     y_next;
    logic                  zero_reg,  zero_next;

    logic [NREQ-1:0]       arb_grant;
    logic [IDXW-1:0]       arb_idx;
    logic                  arb_any;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            y_reg     <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gidx_reg  <= gidx_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            y_reg     <= y_next;
            zero_reg  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gidx_next  = gidx_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        y_next     = y_reg;
        zero_next  = zero_reg;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    op_next    = req_op[int'(arb_idx)*ALU_OP_W +: ALU_OP_W];
                    a_next     = req_a[int'(arb_idx)*ALU_DW +: ALU_DW];
                    b_next     = req_b[int'(arb_idx)*ALU_DW +: ALU_DW];
                    gidx_next  = arb_idx;
                    cnt_next   = '0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg == CW'(ALU_LAT - 1)) begin
                    state_next = CAPT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CAPT: begin
                // ALU has had ALU_LAT enabled edges; its outputs are settled.
                y_next     = alu_y;
                zero_next  = alu_zero;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready[gidx_reg]) begin
                    ptr_next   = IDXW'(wrap_inc(int'(gidx_reg), NREQ));
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst_n so no grant is offered while reset is asserted, even
    // with requests pending.
    assign req_ready = (state_reg == IDLE && rst_n) ? arb_grant : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = (state_reg == RESP) && (gidx_reg == IDXW'(gi));
        end
    endgenerate

    assign rsp_y    = y_reg;
    assign rsp_zero = zero_reg;
    assign busy     = (state_reg != IDLE);
    assign alu_en   = (state_reg == EXEC);
    assign alu_op   = op_reg;
    assign alu_a    = a_reg;
    assign alu_b    = b_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with NREQ=2. Instance dut uses ALU_LAT=1,
// instance dut4 uses ALU_LAT=4 and is held in reset until its own test.
// Each instance drives a stub ALU: y=a+b, zero=(y==0), registered when
// alu_en is high.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rst_n4;
    logic [1:0]  req_valid;
    logic [5:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [1:0]  rsp_ready;

    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_y;
    logic        rsp_zero, busy, alu_en;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [7:0]  alu_y    = 8'h00;
    logic        alu_zero = 1'b0;

    logic [1:0]  req_ready4, rsp_valid4;
    logic [7:0]  rsp_y4;
    logic        rsp_zero4, busy4, alu_en4;
    logic [2:0]  alu_op4;
    logic [7:0]  alu_a4, alu_b4;
    logic [7:0]  alu_y4    = 8'h00;
    logic        alu_zero4 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .busy(busy),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    alu_arbiter #(.NREQ(2), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y4), .rsp_zero(rsp_zero4), .busy(busy4),
        .alu_en(alu_en4), .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4),
        .alu_y(alu_y4), .alu_zero(alu_zero4)
    );

    // Stub ALUs
    logic [7:0] sum1, sum4;
    assign sum1 = alu_a + alu_b;
    assign sum4 = alu_a4 + alu_b4;
    always @(posedge clk) begin
        if (alu_en) begin
            alu_y    <= sum1;
            alu_zero <= (sum1 == 8'h00);
        end
        if (alu_en4) begin
            alu_y4    <= sum4;
            alu_zero4 <= (sum4 == 8'h00);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from requester idx on dut and wait for its response
    // to appear (response handshake left to the caller).
    task automatic issue(input int idx, input string tag);
        int n;
        logic [1:0] oh;
        oh = 2'b01 << idx;
        req_valid = oh;
        #1;
        n = 0;
        while (req_ready[idx] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, req_ready, oh);
        tick();
        req_valid = 2'b00;
        #1;
        n = 0;
        while (rsp_valid === 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, oh);
        $display("txn %s: req%0d y=%02h zero=%b", tag, idx, rsp_y, rsp_zero);
    endtask

    initial begin
        int n;
        int guard;
        int en_cnt;
        logic [1:0] exp_oh;
        logic [7:0] exp_y;
        logic en_seen, changed, rsp_seen;

        rst_n     = 1'b0;
        rst_n4    = 1'b0;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        repeat (2) tick();

        // Reset state, with requests pending
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_alu_opab", {alu_op, alu_a, alu_b}, 19'h0);
        chk("rst_rsp_yz", {rsp_y, rsp_zero}, 9'h0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        // Test 1: single request, 5+3, with exact cycle timing
        req_op    = {3'd0, 3'd2};
        req_a     = {8'h00, 8'h05};
        req_b     = {8'h00, 8'h03};
        req_valid = 2'b01;
        #1;
        chk("t1_req_ready", req_ready, 2'b01);
        tick();                         // accept edge E0
        req_valid = 2'b00;
        #1;
        chk("t1_ready_drop", req_ready, 2'b00);
        chk("t1_alu_en", alu_en, 1'b1);
        chk("t1_alu_a", alu_a, 8'h05);
        chk("t1_alu_b", alu_b, 8'h03);
        chk("t1_alu_op", alu_op, 3'd2);
        chk("t1_busy", busy, 1'b1);
        tick();                         // E0+1
        chk("t1_capt_alu_en", alu_en, 1'b0);
        chk("t1_capt_rsp_valid", rsp_valid, 2'b00);
        tick();                         // E0+2
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_y", rsp_y, 8'h08);
        chk("t1_rsp_zero", rsp_zero, 1'b0);
        $display("txn t1: req0 y=%02h zero=%b", rsp_y, rsp_zero);
        rsp_ready = 2'b01;
        tick();
        chk("t1_rsp_done", rsp_valid, 2'b00);
        chk("t1_idle", busy, 1'b0);
        rsp_ready = 2'b00;

        // Test 2: wrap-around to zero
        req_a = {8'h00, 8'hFF};
        req_b = {8'h00, 8'h01};
        issue(0, "t2");
        chk("t2_rsp_y", rsp_y, 8'h00);
        chk("t2_rsp_zero", rsp_zero, 1'b1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Test 3: fairness from reset, both requesters held valid
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        req_a     = {8'h20, 8'h01};
        req_b     = {8'h02, 8'h10};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_y  = (i % 2 == 0) ? 8'h11 : 8'h22;
            n = 0;
            while (req_ready === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            chk("t3_grant", req_ready, exp_oh);
            tick();
            n = 0;
            while (rsp_valid === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            chk("t3_rsp_valid", rsp_valid, exp_oh);
            chk("t3_rsp_y", rsp_y, exp_y);
            $display("txn t3[%0d]: rsp_valid=%b y=%02h", i, rsp_valid, rsp_y);
            tick();                     // response handshake
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // Test 4: backpressure on req1 while req0 waits; rsp_ready[0] ignored
        req_a     = {8'h10, 8'h01};
        req_b     = {8'h20, 8'h10};
        issue(1, "t4");
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_rsp_valid", rsp_valid, 2'b10);
            chk("t4_stall_rsp_y", rsp_y, 8'h30);
            chk("t4_stall_req_ready", req_ready, 2'b00);
            chk("t4_stall_alu_en", alu_en, 1'b0);
            tick();
        end
        rsp_ready = 2'b10;
        tick();
        chk("t4_release", rsp_valid, 2'b00);
        chk("t4_next_grant", req_ready, 2'b01);
        rsp_ready = 2'b00;
        issue(0, "t4b");
        chk("t4b_rsp_y", rsp_y, 8'h11);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Test 6: idle, ALU inputs hold last issued values (op 2, 01, 10)
        req_valid = 2'b00;
        en_seen = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (alu_en !== 1'b0) en_seen = 1'b1;
            if ({alu_op, alu_a, alu_b} !== {3'd2, 8'h01, 8'h10}) changed = 1'b1;
            tick();
        end
        chk("t6_idle_alu_en", en_seen, 1'b0);
        chk("t6_idle_alu_inputs_changed", changed, 1'b0);
        chk("t6_idle_busy", busy, 1'b0);

        // Test 5: reset in the 2nd EXEC cycle of the ALU_LAT=4 instance
        rst_n4    = 1'b1;
        rsp_ready = 2'b11;
        req_a     = {8'h07, 8'h0C};
        req_b     = {8'h09, 8'h05};
        tick();
        req_valid = 2'b10;
        #1;
        chk("t5_grant1", req_ready4, 2'b10);
        tick();                         // accept edge
        req_valid = 2'b00;
        #1;
        chk("t5_exec1_en", alu_en4, 1'b1);
        tick();
        chk("t5_exec2_en", alu_en4, 1'b1);
        rst_n4    = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t5_rst_alu_en", alu_en4, 1'b0);
        chk("t5_rst_busy", busy4, 1'b0);
        chk("t5_rst_req_ready", req_ready4, 2'b00);
        chk("t5_rst_rsp_valid", rsp_valid4, 2'b00);
        chk("t5_rst_alu_opab", {alu_op4, alu_a4, alu_b4}, 19'h0);
        chk("t5_rst_rsp_yz", {rsp_y4, rsp_zero4}, 9'h0);
        tick();
        req_valid = 2'b00;
        tick();
        rst_n4 = 1'b1;
        rsp_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid4 !== 2'b00 || busy4 !== 1'b0) rsp_seen = 1'b1;
            tick();
        end
        chk("t5_no_rsp_after_reset", rsp_seen, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("t5_grant_after_reset", req_ready4, 2'b01);
        tick();                         // accept edge E0
        req_valid = 2'b00;
        #1;
        guard  = 0;
        en_cnt = 0;
        while (rsp_valid4 === 2'b00 && guard < 20) begin
            if (alu_en4 === 1'b1) en_cnt++;
            tick();
            guard++;
        end
        chk("t5_alu_en_cycles", en_cnt, 4);
        chk("t5_latency", guard, 5);
        chk("t5_rsp_valid", rsp_valid4, 2'b01);
        chk("t5_rsp_y", rsp_y4, 8'h11);
        $display("txn t5: req0 y=%02h zero=%b", rsp_y4, rsp_zero4);
        tick();
        rsp_ready = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
